// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// Ports: imemRequest/imemAddress (fetch -> mem), imemReady/imemData (mem -> fetch).
interface fetch_stage_if;
    logic        imemRequest;
    logic [31:0] imemAddress;
    logic        imemReady;
    logic [31:0] imemData;

    modport master (
        output imemRequest,
        output imemAddress,
        input  imemReady,
        input  imemData
    );

    modport slave (
        input  imemRequest,
        input  imemAddress,
        output imemReady,
        output imemData
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: one outstanding imem request, one-entry skid, redirect/squash.
// Ports: clock, reset, stall, redirectValid/Target, imem (master), if* outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic          redirectValid,
    input  logic [31:0]   redirectTarget,
    fetch_stage_if.master imem,
    output logic [31:0]   ifInstruction,
    output logic [31:0]   ifPc,
    output logic [31:0]   ifPcPlus4,
    output logic          ifValid
);

    typedef enum logic [1:0] {
        ISSUE  = 2'd0,
        WAIT   = 2'd1,
        FULL   = 2'd2,
        SQUASH = 2'd3
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] skidInstr;
    logic [31:0] skidPc;
    logic        slotFree;
    logic        respWait;

    assign slotFree  = !ifValid || !stall;
    assign respWait  = (state == WAIT) && imem.imemReady;
    assign pcPlus4   = pc + 32'd4;
    assign ifPcPlus4 = ifPc + 32'd4;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ISSUE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ISSUE: begin
                stateNext = redirectValid ? ISSUE : WAIT;
            end
            WAIT: begin
                if (redirectValid) begin
                    stateNext = imem.imemReady ? ISSUE : SQUASH;
                end else if (imem.imemReady) begin
                    stateNext = slotFree ? ISSUE : FULL;
                end
            end
            FULL: begin
                if (redirectValid || !stall) begin
                    stateNext = ISSUE;
                end
            end
            SQUASH: begin
                if (imem.imemReady) begin
                    stateNext = ISSUE;
                end
            end
            default: stateNext = ISSUE;
        endcase
    end

    // A redirect arriving in ISSUE withholds the request: the old pc is
    // already dead, and an unsquashed response would alias the new stream.
    always_comb begin
        imem.imemRequest = (state == ISSUE) && !reset && !redirectValid;
        imem.imemAddress = pc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            ifValid       <= 1'b0;
            ifInstruction <= 32'h0;
            ifPc          <= 32'h0;
            skidInstr     <= 32'h0;
            skidPc        <= 32'h0;
        end else if (redirectValid) begin
            // Leaving FULL here is what discards the skid entry.
            pc            <= redirectTarget;
            ifValid       <= 1'b0;
            ifInstruction <= 32'h0;
        end else begin
            if (respWait) begin
                pc <= pcPlus4;
            end
            if (respWait && !slotFree) begin
                skidInstr <= imem.imemData;
                skidPc    <= pc;
            end
            if (respWait && slotFree) begin
                ifValid       <= 1'b1;
                ifInstruction <= imem.imemData;
                ifPc          <= pc;
            end else if ((state == FULL) && !stall) begin
                ifValid       <= 1'b1;
                ifInstruction <= skidInstr;
                ifPc          <= skidPc;
            end else if (!stall) begin
                ifValid       <= 1'b0;
                ifInstruction <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async reset, random stream.
// Ports: drives clock/reset/stall/redirect and the imem slave side.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectTarget = 32'h0;
    logic [31:0] ifInstruction;
    logic [31:0] ifPc;
    logic [31:0] ifPcPlus4;
    logic        ifValid;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirectValid  (redirectValid),
        .redirectTarget (redirectTarget),
        .imem           (bus),
        .ifInstruction  (ifInstruction),
        .ifPc           (ifPc),
        .ifPcPlus4      (ifPcPlus4),
        .ifValid        (ifValid)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9617;
    endfunction

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        ready;
        logic [31:0] data;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc;
    } vec_t;

    vec_t tbl[18];

    logic        memPending;
    int          memWait;
    logic [31:0] memAddr;
    logic [31:0] expPc;
    logic        prevHold;
    logic        prevRedir;
    logic [31:0] prevInstr;
    logic [31:0] prevPc;
    int          consumed;
    int          pick;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h2001_0005, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hAAAA_0001, 1'b0, 32'h0,         1'b1, 32'h2001_0005, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2001_0005, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h2001_0005, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'hAAAA_0001, 32'h4};
        tbl[7]  = '{1'b0, 1'b1, 32'h100,       1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0,         32'h0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_0001, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h104,       1'b1, 32'h1111_0001, 32'h100};
        tbl[12] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h2222_0002, 1'b0, 32'h0,         1'b1, 32'h1111_0001, 32'h100};
        tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3333_0003, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h3333_0003, 32'hFFFF_FFFC};
        tbl[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4444_0004, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        tbl[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h4444_0004, 32'h0};

        bus.imemReady = 1'b0;
        bus.imemData  = 32'h0;

        // Reset state
        @(negedge clock);
        chk1("rstValid", ifValid, 1'b0);
        chk1("rstReq", bus.imemRequest, 1'b0);
        chk("rstInstr", ifInstruction, 32'h0);
        chk("rstPc", ifPc, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            stall          = tbl[i].stall;
            redirectValid  = tbl[i].redir;
            redirectTarget = tbl[i].target;
            bus.imemReady  = tbl[i].ready;
            bus.imemData   = tbl[i].data;
            @(negedge clock);
            chk1($sformatf("v%0d.req", i), bus.imemRequest, tbl[i].eReq);
            if (tbl[i].eReq)
                chk($sformatf("v%0d.addr", i), bus.imemAddress, tbl[i].eAddr);
            chk1($sformatf("v%0d.valid", i), ifValid, tbl[i].eValid);
            chk($sformatf("v%0d.instr", i), ifInstruction, tbl[i].eInstr);
            if (tbl[i].eValid) begin
                chk($sformatf("v%0d.pc", i), ifPc, tbl[i].ePc);
                chk($sformatf("v%0d.pc4", i), ifPcPlus4, tbl[i].ePc + 32'd4);
            end
            @(posedge clock);
            #1;
        end

        // Asynchronous reset while WAIT with a held instruction
        stall         = 1'b0;
        redirectValid = 1'b0;
        bus.imemReady = 1'b0;
        chk1("preRstValid", ifValid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("asyncValid", ifValid, 1'b0);
        chk1("asyncReq", bus.imemRequest, 1'b0);
        chk("asyncInstr", ifInstruction, 32'h0);
        chk("asyncPc", ifPc, 32'h0);
        bus.imemReady = 1'b1;
        bus.imemData  = 32'hBAD0_BAD0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk1("relReq", bus.imemRequest, 1'b1);
        chk("relAddr", bus.imemAddress, 32'h0);
        chk1("relValid", ifValid, 1'b0);
        @(posedge clock);
        #1;
        bus.imemReady = 1'b1;
        bus.imemData  = 32'h5555_0005;
        @(negedge clock);
        chk1("relWaitValid", ifValid, 1'b0);
        @(posedge clock);
        #1 bus.imemReady = 1'b0;
        @(negedge clock);
        chk1("relLoadValid", ifValid, 1'b1);
        chk("relLoadInstr", ifInstruction, 32'h5555_0005);
        chk("relLoadPc", ifPc, 32'h0);
        chk("relNextAddr", bus.imemAddress, 32'h4);

        // Random stream against a program-order model
        @(posedge clock);
        #1 reset = 1'b1;
        stall = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        memPending = 1'b0;
        memWait    = 0;
        memAddr    = 32'h0;
        expPc      = 32'h0;
        prevHold   = 1'b0;
        prevRedir  = 1'b0;
        prevInstr  = 32'h0;
        prevPc     = 32'h0;
        consumed   = 0;
        for (int c = 0; c < 3000; c++) begin
            if (memPending && memWait == 0) begin
                bus.imemReady = 1'b1;
                bus.imemData  = memf(memAddr);
                memPending    = 1'b0;
            end else begin
                bus.imemReady = 1'b0;
                bus.imemData  = $urandom;
                if (memPending) memWait--;
            end
            stall         = ($urandom_range(0, 9) < 4);
            redirectValid = ($urandom_range(0, 19) == 0);
            pick          = $urandom_range(0, 3);
            redirectTarget = (pick == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
            @(negedge clock);
            if (prevHold) begin
                chk1("holdValid", ifValid, 1'b1);
                chk("holdInstr", ifInstruction, prevInstr);
                chk("holdPc", ifPc, prevPc);
            end
            if (prevRedir) begin
                chk1("redirValid", ifValid, 1'b0);
                chk("redirInstr", ifInstruction, 32'h0);
            end
            if (ifValid) begin
                chk("rndData", ifInstruction, memf(ifPc));
                chk("rndPc4", ifPcPlus4, ifPc + 32'd4);
                if (!stall && !redirectValid) begin
                    chk("rndOrder", ifPc, expPc);
                    expPc = ifPc + 32'd4;
                    consumed++;
                end
            end
            if (redirectValid) expPc = redirectTarget;
            if (bus.imemRequest) begin
                chk1("oneOutstanding", memPending, 1'b0);
                memPending = 1'b1;
                memAddr    = bus.imemAddress;
                memWait    = $urandom_range(0, 2);
            end
            prevHold  = ifValid && stall && !redirectValid;
            prevRedir = redirectValid;
            prevInstr = ifInstruction;
            prevPc    = ifPc;
            @(posedge clock);
            #1;
        end
        chk1("progress", consumed > 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port: clock  in  1  single clock, all state rising-edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high.
REQ-004 SHALL have port: stall  in  1  decode holding; output slot not consumed this cycle.
REQ-005 SHALL have port: redirectValid  in  1  branch/jump/jr taken, from decode.
REQ-006 SHALL have port: redirectTarget  in  32  new fetch PC.
REQ-007 SHALL have port: imemRequest  out  1  one-cycle fetch request pulse.
REQ-008 SHALL have port: imemAddress  out  32  word address of request, valid when imemRequest=1.
REQ-009 SHALL have port: imemReady  in  1  response valid, at least 1 cycle after request.
REQ-010 SHALL have port: imemData  in  32  fetched word, valid when imemReady=1.
REQ-011 SHALL have port: ifInstruction  out  32  registered instruction to decode.
REQ-012 SHALL have port: ifPc  out  32  PC of ifInstruction.
REQ-013 SHALL have port: ifPcPlus4  out  32  ifPc+4, mod 2^32.
REQ-014 SHALL have port: ifValid  out  1  ifInstruction holds a live instruction.

Function
REQ-015 SHALL keep internal pc register and FSM with states ISSUE, WAIT, FULL, SQUASH.
REQ-016 SHALL, in ISSUE, drive imemRequest=1 and imemAddress=pc for exactly one cycle, then enter WAIT.
REQ-017 SHALL allow at most one outstanding request; imemRequest=0 in WAIT, FULL, SQUASH.
REQ-018 SHALL treat the output slot as free when ifValid=0 or stall=0.
REQ-019 SHALL, in WAIT on imemReady with free slot, load ifInstruction=imemData, ifPc=pc, ifValid=1, pc<=pc+4, and enter ISSUE.
REQ-020 SHALL, in WAIT on imemReady with slot not free, capture imemData/pc into a one-entry skid buffer, pc<=pc+4, and enter FULL.
REQ-021 SHALL, in FULL when stall=0, move skid into output slot (ifValid=1) and enter ISSUE; with stall=1 SHALL hold.
REQ-022 SHALL clear ifValid and set ifInstruction=0 when stall=0 and no new instruction enters the slot that cycle.
REQ-023 SHALL hold ifInstruction, ifPc, ifValid unchanged while stall=1 and ifValid=1.
REQ-024 SHALL give redirectValid priority over stall and over any response in the same cycle.
REQ-025 SHALL, on redirectValid, set pc<=redirectTarget, ifValid<=0, ifInstruction<=0, and discard the skid entry.
REQ-026 SHALL, on redirect in WAIT with imemReady=0, enter SQUASH; otherwise enter ISSUE.
REQ-027 SHALL, in SQUASH, drop the next imemReady response without updating outputs or pc, then enter ISSUE; a further redirect in SQUASH only updates pc.
REQ-028 SHALL compute pc+4 and ifPcPlus4 with 32-bit wrap (32'hFFFF_FFFC+4 = 0).
REQ-029 SHALL give latency ISSUE cycle t -> ifValid=1 at t+2 for a 1-cycle memory, with no stall.

Reset
REQ-030 SHALL, on reset assertion, immediately set pc=RESET_PC, state=ISSUE, ifValid=0, ifInstruction=0, ifPc=0, skid empty, imemRequest=0 while reset is asserted.
REQ-031 SHALL issue the first request at RESET_PC in the first clock edge after reset deassertion; a response pending at reset SHALL be ignored.

Verification
REQ-032 Reset release, memory returns 32'h2001_0005 one cycle after request -> imemAddress=0, then ifValid=1, ifPc=0, ifPcPlus4=4, next request at 4.
REQ-033 stall=1 with ifValid=1 while response 32'hAAAA_0001 arrives -> outputs unchanged, state FULL, no request; stall=0 -> ifInstruction=32'hAAAA_0001, ifPc=4 next cycle.
REQ-034 redirectValid=1, redirectTarget=32'h0000_0100 while in WAIT, response arrives next cycle -> response dropped, ifValid=0, next imemAddress=32'h0000_0100.
REQ-035 redirectValid and imemReady in the same cycle with stall=1 -> response and output discarded, ifValid=0, next request at redirectTarget.
REQ-036 Redirect to 32'hFFFF_FFFC -> ifPc=32'hFFFF_FFFC, ifPcPlus4=0, next imemAddress=0.
REQ-037 reset asserted mid-WAIT, asynchronously between edges -> ifValid=0, imemRequest=0 without a clock edge; after release request at RESET_PC.
